// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the instruction/data SRAM port arbiter.
// Holds the handshake FSM states and the grant owner encoding.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/sram_port_arbiter.sv
// Multiplexes the fetch and load/store requesters onto one SRAM-like port,
// alternating on conflicts and running the addr_ok/data_ok handshake.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  inst_req,
    input  logic [DATA_W/8-1:0]   inst_wen,
    input  logic [ADDR_W-1:0]     inst_addr,
    input  logic [DATA_W-1:0]     inst_wdata,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_done,

    input  logic                  data_req,
    input  logic [DATA_W/8-1:0]   data_wen,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_done,

    output logic                  mem_req,
    output logic [DATA_W/8-1:0]   mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  stallreq
);

    localparam int BE_W = DATA_W / 8;

    state_t              state, state_nxt;
    logic                grant, grant_nxt;
    logic                last_grant, last_grant_nxt;
    logic [DATA_W-1:0]   rdata_q, rdata_nxt;

    logic                pick;
    logic [BE_W-1:0]     sel_wen;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   capture;

    // Requesters hold their payload until done, so muxing by grant is stable.
    always_comb begin
        sel_wen   = (grant == GRANT_DATA) ? data_wen   : inst_wen;
        sel_addr  = (grant == GRANT_DATA) ? data_addr  : inst_addr;
        sel_wdata = (grant == GRANT_DATA) ? data_wdata : inst_wdata;
        capture   = (sel_wen == '0) ? mem_rdata : '0;
    end

    // On a conflict the requester that did not win last time goes first.
    always_comb begin
        if (inst_req && data_req)
            pick = ~last_grant;
        else if (data_req)
            pick = GRANT_DATA;
        else
            pick = GRANT_INST;
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        rdata_nxt      = rdata_q;
        mem_req        = 1'b0;
        mem_wen        = '0;
        mem_addr       = '0;
        mem_wdata      = '0;
        inst_done      = 1'b0;
        data_done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    state_nxt      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_req   = 1'b1;
                mem_wen   = sel_wen;
                mem_addr  = sel_addr;
                mem_wdata = sel_wdata;
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        rdata_nxt = capture;
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    rdata_nxt = capture;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                inst_done = (grant == GRANT_INST);
                data_done = (grant == GRANT_DATA);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant      <= GRANT_INST;
            last_grant <= GRANT_INST;
            rdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            rdata_q    <= rdata_nxt;
        end
    end

    assign inst_rdata = rdata_q;
    assign data_rdata = rdata_q;
    assign stallreq   = (inst_req & ~inst_done) | (data_req & ~data_done);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: single read, conflicts, write,
// combined handshake, wait states and reset in the middle of a transfer.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req;
    logic [3:0]  inst_wen, data_wen;
    logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_done, data_done;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        stallreq;

    int vectors     = 0;
    int miscompares = 0;
    int done_count;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_wen    (inst_wen),
        .inst_addr   (inst_addr),
        .inst_wdata  (inst_wdata),
        .inst_rdata  (inst_rdata),
        .inst_done   (inst_done),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .mem_req     (mem_req),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .stallreq    (stallreq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        inst_req = 0; inst_wen = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        tick(); tick();
        check("rst_mem_req",   mem_req, 0);
        check("rst_mem_addr",  mem_addr, 0);
        check("rst_dones",     {inst_done, data_done}, 0);
        check("rst_rdata",     inst_rdata, 0);
        check("rst_stall_idle", stallreq, 0);
        inst_req = 1; #1;
        check("rst_stall_follows", stallreq, 1);
        inst_req = 0;
        rst = 1'b1;

        // Single read: request at N, addr_ok at N+1, data_ok at N+2, done at N+3
        tick();
        inst_req = 1; inst_addr = 32'hBFC0_0000; inst_wen = 0; #1;
        check("rd_N_stall", stallreq, 1);
        check("rd_N_mem_req", mem_req, 0);
        tick();
        mem_addr_ok = 1; #1;
        check("rd_N1_mem_req", mem_req, 1);
        check("rd_N1_mem_addr", mem_addr, 32'hBFC0_0000);
        check("rd_N1_stall", stallreq, 1);
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3C1D_0001; #1;
        check("rd_N2_mem_req", mem_req, 0);
        check("rd_N2_mem_addr_idle", mem_addr, 0);
        check("rd_N2_stall", stallreq, 1);
        tick();
        mem_data_ok = 0; mem_rdata = 0; #1;
        check("rd_N3_done", {inst_done, data_done}, 2'b10);
        check("rd_N3_rdata", inst_rdata, 32'h3C1D_0001);
        check("rd_N3_stall", stallreq, 0);
        tick();
        inst_req = 0; #1;
        check("rd_N4_done_low", inst_done, 0);

        // Conflict after reset: last_grant=inst, so data wins first
        inst_req = 1; inst_addr = 32'h0000_1000; inst_wen = 0;
        data_req = 1; data_addr = 32'h0000_2000; data_wen = 0; #1;
        tick();
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0000_00D1; #1;
        check("cf1_mem_addr_data", mem_addr, 32'h0000_2000);
        tick();
        mem_addr_ok = 0; mem_data_ok = 0; #1;
        check("cf1_done", {inst_done, data_done}, 2'b01);
        check("cf1_rdata", data_rdata, 32'h0000_00D1);
        check("cf1_stall_inst_waiting", stallreq, 1);
        tick();
        data_req = 0; #1;
        tick();
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0000_00A1; #1;
        check("cf1_mem_addr_inst", mem_addr, 32'h0000_1000);
        tick();
        mem_addr_ok = 0; mem_data_ok = 0; #1;
        check("cf1_inst_done", {inst_done, data_done}, 2'b10);
        check("cf1_inst_rdata", inst_rdata, 32'h0000_00A1);
        tick();
        inst_req = 0; #1;
        // Second conflict: inst was last, so data wins again
        inst_req = 1; data_req = 1; #1;
        tick();
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0000_00D2; #1;
        check("cf2_mem_addr_data", mem_addr, 32'h0000_2000);
        tick();
        mem_addr_ok = 0; mem_data_ok = 0; #1;
        check("cf2_done", {inst_done, data_done}, 2'b01);
        tick();
        data_req = 0; #1;
        tick();
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0000_00A2; #1;
        check("cf2_mem_addr_inst", mem_addr, 32'h0000_1000);
        tick();
        mem_addr_ok = 0; mem_data_ok = 0; #1;
        check("cf2_inst_done", inst_done, 1);
        tick();
        inst_req = 0; #1;

        // Write: payload visible in ADDR, rdata cleared on completion
        data_req = 1; data_wen = 4'b0011; data_addr = 32'h8000_0010; data_wdata = 32'h1234_ABCD; #1;
        check("wr_idle_mem_wen", mem_wen, 0);
        tick();
        mem_addr_ok = 1; #1;
        check("wr_mem_wen", mem_wen, 4'b0011);
        check("wr_mem_addr", mem_addr, 32'h8000_0010);
        check("wr_mem_wdata", mem_wdata, 32'h1234_ABCD);
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hFFFF_FFFF; #1;
        check("wr_data_mem_wdata_idle", mem_wdata, 0);
        tick();
        mem_data_ok = 0; #1;
        check("wr_done", {inst_done, data_done}, 2'b01);
        check("wr_rdata_zero", data_rdata, 0);
        tick();
        data_req = 0; data_wen = 0; #1;

        // Combined handshake: DATA skipped, done one cycle after ADDR
        inst_req = 1; inst_addr = 32'h0000_3000; #1;
        tick();
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF; #1;
        check("cmb_mem_req", mem_req, 1);
        tick();
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0; #1;
        check("cmb_done", inst_done, 1);
        check("cmb_rdata", inst_rdata, 32'hDEAD_BEEF);
        tick();
        inst_req = 0; #1;

        // Wait states: addr_ok after 3 ADDR cycles, data_ok after 2 DATA cycles
        done_count = 0;
        data_req = 1; data_addr = 32'h0000_4000; data_wen = 0; #1;
        tick();
        // data_ok without addr_ok is ignored in ADDR
        mem_data_ok = 1; mem_rdata = 32'h1111_1111; #1;
        for (int i = 0; i < 3; i++) begin
            check("ws_addr_mem_req", mem_req, 1);
            check("ws_addr_stall", stallreq, 1);
            done_count += int'(data_done);
            tick();
            mem_data_ok = 0; #1;
        end
        mem_addr_ok = 1; #1;
        check("ws_addr_last_mem_req", mem_req, 1);
        tick();
        mem_addr_ok = 0; #1;
        for (int i = 0; i < 2; i++) begin
            check("ws_data_mem_req", mem_req, 0);
            check("ws_data_stall", stallreq, 1);
            done_count += int'(data_done);
            tick();
        end
        mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D; #1;
        check("ws_data_last_mem_req", mem_req, 0);
        tick();
        mem_data_ok = 0; mem_rdata = 0; #1;
        done_count += int'(data_done);
        check("ws_rdata", data_rdata, 32'h0BAD_F00D);
        tick();
        data_req = 0; #1;
        done_count += int'(data_done);
        check("ws_one_done", done_count, 1);

        // Reset while in DATA
        inst_req = 1; inst_addr = 32'h0000_5000; #1;
        tick();
        mem_addr_ok = 1; #1;
        tick();
        mem_addr_ok = 0; #1;
        rst = 1'b0; #1;
        check("rstmid_mem_req", mem_req, 0);
        check("rstmid_done", {inst_done, data_done}, 0);
        check("rstmid_rdata", inst_rdata, 0);
        inst_req = 0;
        tick();
        rst = 1'b1;
        mem_data_ok = 1; mem_rdata = 32'h7777_7777; #1;
        tick();
        mem_data_ok = 0; #1;
        check("rstmid_stray_no_done", {inst_done, data_done}, 0);
        check("rstmid_stray_rdata", inst_rdata, 0);
        inst_req = 1; inst_addr = 32'h0000_6000; #1;
        check("rstmid_new_idle", mem_req, 0);
        tick();
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0000_6666; #1;
        check("rstmid_new_addr", mem_addr, 32'h0000_6000);
        tick();
        mem_addr_ok = 0; mem_data_ok = 0; #1;
        check("rstmid_new_done", inst_done, 1);
        check("rstmid_new_rdata", inst_rdata, 32'h0000_6666);
        tick();
        inst_req = 0; #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
